mux8_rr_sched: RTL and testbench

Round-robin scheduler that shares the 8:1 select mux between eight requesters. It watches per-input request lines, grants one requester at a time, and drives the mux select bus so that the granted input reaches `y`. Each grant is bounded by a programmable hold limit, which keeps any single input from monopolising the output. The block sits directly in front of the `mux` select port; the mux data path itself is unchanged.

---
 rtl/mux8_rr_sched.sv | 74 +++++++
 tb/tb_mux8_rr_sched.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_sched.sv
// mux8_rr_sched: round-robin scheduler driving the 8:1 mux select with a bounded hold per grant
// Ports: clk, rst_n (async active-low), req[0:7] requests, gnt[0:7] one-hot grant (registered),
//        sel[0:2] mux select (sel[0] is MSB, registered), valid = OR of gnt.
module mux8_rr_sched #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [0:7] req,
  output logic [0:7] gnt,
  output logic [0:2] sel,
  output logic       valid
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t     state, state_nx;
  logic [2:0] owner, owner_nx, ptr, ptr_nx, base, idx, win;
  logic [3:0] cnt, cnt_nx;
  logic [0:7] gnt_nx;
  logic [2:0] sel_nx;
  logic       found, rel;
  assign valid = |gnt;
  // On release the priority pointer moves past the current owner in the same edge,
  // so arbitration starts from owner+1 rather than the stored ptr.
  always_comb begin
    rel   = (state == GRANT) && (!req[owner] || cnt == 4'(MAX_HOLD));
    base  = (state == GRANT) ? owner + 3'd1 : ptr;
    found = 1'b0;
    win   = 3'd0;
    idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      idx = base + 3'(i);
      if (req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    state_nx = state;
    owner_nx = owner;
    ptr_nx   = ptr;
    cnt_nx   = cnt;
    gnt_nx   = gnt;
    sel_nx   = sel;
    if (state == GRANT && !rel) cnt_nx = cnt + 4'd1;
    if (rel) ptr_nx = owner + 3'd1;
    if ((state == IDLE || rel) && found) begin
      state_nx    = GRANT;
      owner_nx    = win;
      cnt_nx      = 4'd1;
      gnt_nx      = '0;
      gnt_nx[win] = 1'b1;
      sel_nx      = win;
    end else if (rel) begin
      state_nx = IDLE;
      gnt_nx   = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 3'd0;
      ptr   <= 3'd0;
      cnt   <= 4'd0;
      gnt   <= '0;
      sel   <= 3'd0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      ptr   <= ptr_nx;
      cnt   <= cnt_nx;
      gnt   <= gnt_nx;
      sel   <= sel_nx;
    end
  end
endmodule

// File: tb/tb_mux8_rr_sched.sv
// tb_mux8_rr_sched: directed and randomized checks of mux8_rr_sched against a reference model
module tb_mux8_rr_sched;
  localparam int MAX_HOLD = 4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [0:7] req = '0;
  logic [0:7] gnt;
  logic [0:2] sel;
  logic       valid;
  int vecs = 0;
  int errs = 0;
  int m_owner = -1;
  int m_ptr = 0;
  int m_cnt = 0;
  int m_sel = 0;
  mux8_rr_sched #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .sel(sel), .valid(valid)
  );
  always #5 clk = ~clk;
  function automatic int arb(input logic [0:7] r, input int start);
    for (int i = 0; i < 8; i++)
      if (r[(start + i) % 8]) return (start + i) % 8;
    return -1;
  endfunction
  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    m_sel   = 0;
  endtask
  task automatic model_step(input logic [0:7] r);
    int w;
    if (m_owner >= 0 && r[m_owner] && m_cnt < MAX_HOLD) begin
      m_cnt++;
      return;
    end
    if (m_owner >= 0) m_ptr = (m_owner + 1) % 8;
    w = arb(r, m_ptr);
    if (w >= 0) begin
      m_owner = w;
      m_cnt   = 1;
      m_sel   = w;
    end else begin
      m_owner = -1;
    end
  endtask
  task automatic check(input string tag);
    logic [0:7] eg;
    logic [2:0] es;
    logic       ev;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    es = 3'(m_sel);
    ev = (m_owner >= 0);
    vecs++;
    assert (gnt === eg) else begin
      errs++;
      $error("FAIL %s gnt observed=%b expected=%b", tag, gnt, eg);
    end
    vecs++;
    assert (sel === es) else begin
      errs++;
      $error("FAIL %s sel observed=%b expected=%b", tag, sel, es);
    end
    vecs++;
    assert (valid === ev) else begin
      errs++;
      $error("FAIL %s valid observed=%b expected=%b", tag, valid, ev);
    end
  endtask
  task automatic cyc(input logic [0:7] r, input string tag);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
    check(tag);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = 8'($urandom);
    model_reset();
    #1;
    check("reset_hold");
    @(negedge clk);
    req = '0;
    rst_n = 1'b1;
  endtask
  initial begin
    logic [0:7] r;
    model_reset();
    req = 8'($urandom);
    repeat (2) @(posedge clk);
    #1;
    check("reset");
    @(negedge clk);
    req = '0;
    rst_n = 1'b1;
    repeat (2) cyc(8'b00000000, "idle_after_reset");
    for (int i = 0; i < 10; i++) cyc(8'b00010000, "lone_k3");
    vecs++;
    assert (gnt === 8'b00010000 && sel === 3'b011) else begin
      errs++;
      $error("FAIL lone_k3_direct observed gnt=%b sel=%b expected gnt=00010000 sel=011", gnt, sel);
    end
    do_reset();
    for (int i = 0; i < 36; i++) cyc(8'hFF, "full_contention");
    do_reset();
    cyc(8'b00100100, "prio_first");
    vecs++;
    assert (gnt === 8'b00100000) else begin
      errs++;
      $error("FAIL prio_first_direct gnt observed=%b expected=00100000", gnt);
    end
    cyc(8'b00100100, "prio_hold");
    cyc(8'b00000100, "early_release");
    vecs++;
    assert (gnt === 8'b00000100 && sel === 3'b101) else begin
      errs++;
      $error("FAIL early_release_direct observed gnt=%b sel=%b expected gnt=00000100 sel=101", gnt, sel);
    end
    cyc(8'b00000010, "to_k6");
    cyc(8'b00000010, "hold_k6");
    cyc(8'b00000000, "idle_k6");
    vecs++;
    assert (gnt === 8'b0 && valid === 1'b0 && sel === 3'b110) else begin
      errs++;
      $error("FAIL idle_k6_direct observed gnt=%b valid=%b sel=%b expected 00000000/0/110", gnt, valid, sel);
    end
    cyc(8'b10000001, "ptr7_pick");
    vecs++;
    assert (gnt === 8'b00000001) else begin
      errs++;
      $error("FAIL ptr7_direct gnt observed=%b expected=00000001", gnt);
    end
    cyc(8'b10000000, "ptr7_then0");
    cyc(8'b00001000, "k4_grant");
    cyc(8'b00001000, "k4_hold");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    cyc(8'b10001000, "after_async");
    vecs++;
    assert (gnt === 8'b10000000) else begin
      errs++;
      $error("FAIL after_async_direct gnt observed=%b expected=10000000", gnt);
    end
    r = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 8'($urandom);
      cyc(r, "random");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
